// File: rtl/peripheral_result_bridge_pkg.sv
// Shared definitions for the peripheral result bridge.
//
// Contents:
//   HdrNibble   - upper nibble of every frame header byte
//   FrameLen    - bytes per serialized frame (header + 4 data bytes)
//   EntryWidth  - width of one buffered entry: {sel[1:0], data[31:0]}
//   state_e     - serializer FSM encoding
//   frame_byte  - selects the byte presented in a given serializer state

package peripheral_result_bridge_pkg;

    localparam logic [3:0]  HdrNibble  = 4'hA;
    localparam int unsigned FrameLen   = 5;
    localparam int unsigned EntryWidth = 34;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StD3,
        StD2,
        StD1,
        StD0
    } state_e;

    // Byte on the stream for a given state; zero when idle.
    function automatic logic [7:0] frame_byte(input state_e st, input logic [1:0] core_id,
                                              input logic [EntryWidth-1:0] entry);
        logic [7:0] b;
        b = 8'h00;
        unique case (st)
            StHdr:   b = {HdrNibble, core_id, entry[33:32]};
            StD3:    b = entry[31:24];
            StD2:    b = entry[23:16];
            StD1:    b = entry[15:8];
            StD0:    b = entry[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/peripheral_result_bridge_sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers.
//
// Parameters:
//   WIDTH      - entry width
//   DEPTH_BITS - log2 of the entry count
// Ports:
//   clock, reset        - clock, asynchronous active-low reset
//   push, push_data     - write request and data
//   pop, pop_data       - read request; pop_data is the current head (show-ahead)
//   full, empty, level  - occupancy status, all decoded from the pointers
//
// The caller guarantees it never pops when empty and never pushes when full unless it
// pops in the same cycle.

module sync_fifo #(
    parameter int unsigned WIDTH      = 34,
    parameter int unsigned DEPTH_BITS = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_BITS:0]   level
);

    localparam int unsigned        Depth   = 2 ** DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] PtrOne  = 1;
    localparam logic [DEPTH_BITS:0] FullXor = {1'b1, {DEPTH_BITS{1'b0}}};

    logic [WIDTH-1:0]    mem_q [Depth];
    logic [DEPTH_BITS:0] wptr_q;
    logic [DEPTH_BITS:0] rptr_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PtrOne;
            if (pop)  rptr_q <= rptr_q + PtrOne;
        end
    end

    // Storage needs no reset: the pointers alone define which slots are valid.
    always_ff @(posedge clock) begin
        if (push) mem_q[wptr_q[DEPTH_BITS-1:0]] <= push_data;
    end

    always_comb begin
        pop_data = mem_q[rptr_q[DEPTH_BITS-1:0]];
        empty    = (wptr_q == rptr_q);
        full     = ((wptr_q ^ rptr_q) == FullXor);
        level    = wptr_q - rptr_q;
    end

endmodule

// File: rtl/peripheral_result_bridge.sv
// peripheral_result_bridge: buffers core result writes and serializes each into a
// 5-byte frame {hdr, d[31:24], d[23:16], d[15:8], d[7:0]} on a byte ready/valid stream.
//
// Parameters:
//   CORE       - core ID carried in header bits [3:2]
//   DEPTH_BITS - FIFO holds 2**DEPTH_BITS entries
// Ports:
//   clock, reset                     - clock, asynchronous active-low reset
//   to_peripheral[1:0]               - result channel select
//   to_peripheral_data[31:0]         - result value
//   to_peripheral_valid              - one-cycle strobe per result (never stalled)
//   tx_byte[7:0], tx_valid, tx_ready - outgoing byte stream
//   fifo_level                       - FIFO occupancy
//   drop_count[15:0]                 - saturating count of entries lost to a full FIFO
//   busy                             - FIFO non-empty or a frame in flight

module peripheral_result_bridge
    import peripheral_result_bridge_pkg::*;
#(
    parameter int unsigned CORE       = 0,
    parameter int unsigned DEPTH_BITS = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            to_peripheral,
    input  logic [31:0]           to_peripheral_data,
    input  logic                  to_peripheral_valid,
    output logic [7:0]            tx_byte,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [DEPTH_BITS:0]   fifo_level,
    output logic [15:0]           drop_count,
    output logic                  busy
);

    localparam logic [1:0] CoreId = 2'(CORE);

    state_e                state_q, state_d;
    logic [EntryWidth-1:0] frame_q, frame_d;
    logic [15:0]           drop_q, drop_d;

    logic                  push;
    logic                  pop;
    logic [EntryWidth-1:0] head;
    logic                  fifo_full;
    logic                  fifo_empty;

    sync_fifo #(
        .WIDTH      (EntryWidth),
        .DEPTH_BITS (DEPTH_BITS)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data ({to_peripheral, to_peripheral_data}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Serializer: a pop always loads the frame register and restarts at the header,
    // so back-to-back frames have no idle bubble.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    frame_d = head;
                    state_d = StHdr;
                end
            end
            StHdr: if (tx_ready) state_d = StD3;
            StD3:  if (tx_ready) state_d = StD2;
            StD2:  if (tx_ready) state_d = StD1;
            StD1:  if (tx_ready) state_d = StD0;
            StD0: begin
                if (tx_ready) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        frame_d = head;
                        state_d = StHdr;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A full FIFO still accepts when the serializer pops in the same cycle.
    always_comb begin
        push   = to_peripheral_valid && (!fifo_full || pop);
        drop_d = drop_q;
        if (to_peripheral_valid && !push && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            frame_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            drop_q  <= drop_d;
        end
    end

    // Outputs decode registered state only; tx_ready never reaches them combinationally.
    always_comb begin
        tx_valid   = (state_q != StIdle);
        tx_byte    = frame_byte(state_q, CoreId, frame_q);
        drop_count = drop_q;
        busy       = (fifo_level != '0) || (state_q != StIdle);
    end

endmodule

// File: tb/tb_peripheral_result_bridge.sv
// Self-checking bench for peripheral_result_bridge (CORE=0, DEPTH_BITS=3).
// Stimulus pushes expected frame bytes into a queue; a monitor on the falling edge
// pops and compares every accepted byte and checks that stalled bytes stay stable.

module tb_peripheral_result_bridge;
    import peripheral_result_bridge_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  to_peripheral;
    logic [31:0] to_peripheral_data;
    logic        to_peripheral_valid;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  fifo_level;
    logic [15:0] drop_count;
    logic        busy;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    logic        hold_pending = 1'b0;
    logic [7:0]  held_byte = 8'h00;

    peripheral_result_bridge #(
        .CORE       (0),
        .DEPTH_BITS (3)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .to_peripheral       (to_peripheral),
        .to_peripheral_data  (to_peripheral_data),
        .to_peripheral_valid (to_peripheral_valid),
        .tx_byte             (tx_byte),
        .tx_valid            (tx_valid),
        .tx_ready            (tx_ready),
        .fifo_level          (fifo_level),
        .drop_count          (drop_count),
        .busy                (busy)
    );

    initial forever #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One-cycle strobe; queues the expected frame when the entry should be accepted.
    task automatic push_entry(input logic [1:0] sel, input logic [31:0] data,
                              input bit accepted);
        to_peripheral       = sel;
        to_peripheral_data  = data;
        to_peripheral_valid = 1'b1;
        if (accepted) begin
            exp_q.push_back({4'hA, 2'b00, sel});
            exp_q.push_back(data[31:24]);
            exp_q.push_back(data[23:16]);
            exp_q.push_back(data[15:8]);
            exp_q.push_back(data[7:0]);
        end
        tick();
        to_peripheral_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while ((busy || exp_q.size() != 0) && i < 200) begin
            tick();
            i++;
        end
        check({name, " busy after drain"}, 32'(busy), 32'd0);
        check({name, " bytes outstanding"}, exp_q.size(), 32'd0);
    endtask

    // Monitor: compares accepted bytes against the scoreboard and checks hold stability.
    initial forever begin
        logic [7:0] e;
        @(negedge clock);
        if (reset) begin
            if (hold_pending) begin
                n_cmp++;
                if (!tx_valid || tx_byte !== held_byte) begin
                    n_err++;
                    $display("FAIL hold: got valid=%0b byte=%0h, expected valid=1 byte=%0h",
                             tx_valid, tx_byte, held_byte);
                end
            end
            hold_pending = tx_valid && !tx_ready;
            held_byte    = tx_byte;
            if (tx_valid && tx_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL stream: got unexpected byte %0h, expected none", tx_byte);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_byte !== e) begin
                        n_err++;
                        $display("FAIL stream: got %0h, expected %0h", tx_byte, e);
                    end
                end
            end
        end else begin
            hold_pending = 1'b0;
        end
    end

    initial begin
        int cyc, first_v, last_v, cnt_v, peak, cnt;

        reset               = 1'b0;
        to_peripheral       = 2'b00;
        to_peripheral_data  = 32'h0;
        to_peripheral_valid = 1'b0;
        tx_ready            = 1'b1;

        // Reset values.
        #12;
        check("rst tx_valid", 32'(tx_valid), 32'd0);
        check("rst tx_byte", 32'(tx_byte), 32'd0);
        check("rst fifo_level", 32'(fifo_level), 32'd0);
        check("rst drop_count", 32'(drop_count), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        reset = 1'b1;
        tick();

        // Single frame: latency and contiguity.
        push_entry(2'b01, 32'h12345678, 1'b1);
        check("t1 level after push", 32'(fifo_level), 32'd1);
        check("t1 valid after push", 32'(tx_valid), 32'd0);
        tick();
        check("t1 header valid", 32'(tx_valid), 32'd1);
        check("t1 header byte", 32'(tx_byte), 32'hA1);
        for (int i = 1; i < FrameLen; i++) begin
            tick();
            check("t1 contiguous", 32'(tx_valid), 32'd1);
        end
        tick();
        check("t1 busy after frame", 32'(busy), 32'd0);

        // Back-to-back frames.
        cyc = 0; first_v = -1; last_v = -1; cnt_v = 0; peak = 0;
        for (int k = 0; k < 28; k++) begin
            if (k == 0)      push_entry(2'b10, 32'hA1B2C3D4, 1'b1);
            else if (k == 1) push_entry(2'b11, 32'h0F1E2D3C, 1'b1);
            else if (k == 2) push_entry(2'b00, 32'h55AA55AA, 1'b1);
            else             tick();
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
            if (tx_valid) begin
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
                cnt_v++;
            end
            cyc++;
        end
        check("t2 valid cycles", cnt_v, 32'd15);
        check("t2 no gap", last_v - first_v + 1, 32'd15);
        check("t2 level peak", peak, 32'd2);
        drain("t2");

        // Backpressure: ready alternates 1,0,1,0,... during the frame.
        push_entry(2'b10, 32'hCAFEF00D, 1'b1);
        tick();
        cnt = 0;
        while (tx_valid && cnt < 20) begin
            tx_ready = (cnt % 2 == 0);
            cnt++;
            tick();
        end
        tx_ready = 1'b1;
        check("t3 frame cycles", cnt, 32'd9);
        drain("t3");

        // Overflow: sink stalled, 12 pushes.
        tx_ready = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            push_entry(2'(k % 4), 32'(k) * 32'h11111111, k <= 9);
        end
        check("t4 fifo_level", 32'(fifo_level), 32'd8);
        check("t4 drop_count", 32'(drop_count), 32'd3);
        check("t4 header held", 32'(tx_byte), 32'hA1);

        // Full FIFO: push lands in the same cycle as D0 acceptance.
        tx_ready = 1'b1;
        repeat (4) tick();
        check("t5 at D0", 32'(tx_byte), 32'h11);
        push_entry(2'b01, 32'hDDDDDDDD, 1'b1);
        check("t5 level held", 32'(fifo_level), 32'd8);
        check("t5 no drop", 32'(drop_count), 32'd3);
        drain("t5");

        // Reset in the middle of a frame.
        push_entry(2'b11, 32'hAABBCCDD, 1'b1);
        repeat (3) tick();
        check("t6 at D2", 32'(tx_byte), 32'hBB);
        #2;
        reset = 1'b0;
        #1;
        check("t6 rst tx_valid", 32'(tx_valid), 32'd0);
        check("t6 rst tx_byte", 32'(tx_byte), 32'd0);
        check("t6 rst fifo_level", 32'(fifo_level), 32'd0);
        check("t6 rst drop_count", 32'(drop_count), 32'd0);
        check("t6 rst busy", 32'(busy), 32'd0);
        exp_q.delete();
        @(posedge clock);
        #3;
        reset = 1'b1;
        tick();
        push_entry(2'b00, 32'hDEADBEEF, 1'b1);
        drain("t6");

        check("final queue empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/peripheral_result_bridge.md
# peripheral_result_bridge

Downstream consumer of the core's result port (`to_peripheral`, `to_peripheral_data`, `to_peripheral_valid`). It buffers each reported register write in a small FIFO and serializes every entry into a 5-byte frame on a byte-wide ready/valid stream toward the host/UART side. The core never stalls on this block. Entries arriving while the FIFO is full are dropped and counted.

## Interface
- `CORE`, 0: core ID, placed in the frame header.
- `DEPTH_BITS`, 3: FIFO depth is 2^DEPTH_BITS entries (8).
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; clears all state.
- `to_peripheral` input 2: result channel select from the core.
- `to_peripheral_data` input 32: result value.
- `to_peripheral_valid` input 1: one-cycle strobe per result.
- `tx_byte` output 8: serialized frame byte.
- `tx_valid` output 1: `tx_byte` is valid.
- `tx_ready` input 1: sink accepts the byte when `tx_valid && tx_ready`.
- `fifo_level` output DEPTH_BITS+1: current FIFO occupancy (0..2^DEPTH_BITS).
- `drop_count` output 16: count of dropped entries, saturating.
- `busy` output 1: high when the FIFO is non-empty or a frame is in flight.

## Operation
- Push: on `to_peripheral_valid`, write {`to_peripheral`, `to_peripheral_data`} (34 b) at the write pointer if the FIFO is not full after this cycle's pop. Otherwise drop the entry and increment `drop_count`; it saturates at 16'hFFFF.
- Pointers are DEPTH_BITS+1 bits wide with wrap bit. Full when the pointers differ only in the MSB; empty when they are equal.
- FSM states: IDLE, HDR, D3, D2, D1, D0.
  - IDLE: if the FIFO is non-empty, pop the head into the frame register and go to HDR. Otherwise stay.
  - HDR: `tx_byte` = {4'hA, CORE[1:0], sel[1:0]}.
  - D3, D2, D1, D0: `tx_byte` = data[31:24], [23:16], [15:8], [7:0]. Data is sent MSB first.
  - Advance HDR→D3→D2→D1→D0 only on `tx_valid && tx_ready`.
  - D0 accepted: if the FIFO is non-empty, pop and go to HDR (back-to-back frames, no idle bubble). Otherwise go to IDLE.
- `tx_valid` = 1 in all states except IDLE. `tx_byte` is stable while `tx_valid && !tx_ready`. `tx_byte` = 0 in IDLE.
- Simultaneous push and pop: both take effect. A push when full succeeds if a pop occurs in the same cycle. `fifo_level` is unchanged.
- `busy` = (`fifo_level` != 0) || (state != IDLE).

## Timing
- Reset values: state IDLE, pointers 0, `tx_valid` 0, `tx_byte` 0, `fifo_level` 0, `drop_count` 0, `busy` 0. Reset asserted mid-frame aborts the frame immediately; the partial frame is lost.
- Latency, empty block:
  - Push at edge N.
  - `fifo_level` = 1 after edge N.
  - Pop and IDLE→HDR at edge N+1.
  - `tx_valid` = 1 with the header from edge N+1.
- Throughput: 5 bytes per entry at `tx_ready` = 1, i.e. one entry per 5 cycles sustained. Core bursts longer than the FIFO depth plus the in-flight entry are dropped.
- All outputs are registered or decoded from registered state only. There is no combinational path from `tx_ready` to `tx_valid` or `tx_byte`.

## Structure
- Shared package: the frame header nibble constant 4'hA, the FSM state encoding, and the frame length constant 5.
- One sub-module, `sync_fifo` (parameters WIDTH=34, DEPTH_BITS), providing push/pop/full/empty/level. The FSM, serializer and drop counter live in the top module.

## Test plan
- Single push, data 32'h12345678, sel 2'b01, CORE=0, `tx_ready`=1 → bytes A1, 12, 34, 56, 78 on 5 consecutive cycles, starting 1 cycle after the push; then `busy`=0.
- Back-to-back: 3 pushes on consecutive cycles, `tx_ready`=1 → 15 bytes with no gap; `fifo_level` peaks at 2.
- Backpressure: `tx_ready` toggles 1,0,1,0 during a frame → each byte is held stable while `tx_ready`=0; the frame completes in 9 cycles.
- Overflow: `tx_ready`=0, 12 pushes → `fifo_level`=8, 1 entry held in the frame register, `drop_count`=3.
- Full plus simultaneous push/pop: FIFO full, D0 accepted in the same cycle as a push → no drop; `fifo_level` stays 8.
- Reset asserted during D2 → outputs return to reset values asynchronously. After release, a push of 32'hDEADBEEF yields a clean frame A0, DE, AD, BE, EF.
